// File: rtl/fma_arb_pkg.sv
// Shared widths and helpers for the FMA round-robin scheduler.
// Widths are derived from the Q(INTW).(FRACW) operand format.
package fma_arb_pkg;

   localparam int DEF_NREQ = 4;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int opw_f(input int intw, input int fracw);
      return intw + fracw;
   endfunction

   // Addend/result keep the full fractional precision of the product.
   function automatic int accw_f(input int intw, input int fracw);
      return intw + 2 * fracw;
   endfunction

   function automatic int idw_f(input int nreq);
      return (clog2(nreq) > 1) ? clog2(nreq) : 1;
   endfunction

   typedef logic [idw_f(DEF_NREQ)-1:0] req_id_t;

endpackage

// File: rtl/fma_rr_scheduler_tag_fifo.sv
// In-order FIFO of requester IDs for ops currently inside the FMA core.
// DEPTH must be a power of two (>=2) so the pointers wrap naturally.
module tag_fifo
   import fma_arb_pkg::*;
#(
   parameter int W     = 2,
   parameter int DEPTH = 4,
   localparam int AW   = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
   localparam int CW   = clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fma_rr_scheduler.sv
// Round-robin issue scheduler sharing one in-order FMA pipeline among NREQ
// requesters; issued IDs ride a tag FIFO so each result returns to its owner.
module fma_rr_scheduler
   import fma_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int INTW  = 16,
   parameter int FRACW = 16,
   parameter int DEPTH = 4,
   localparam int OPW  = opw_f(INTW, FRACW),
   localparam int ACCW = accw_f(INTW, FRACW),
   localparam int IDW  = idw_f(NREQ),
   localparam int CW   = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [NREQ*OPW-1:0]  req_a,
   input  logic [NREQ*OPW-1:0]  req_b,
   input  logic [NREQ*ACCW-1:0] req_c,
   output logic             fma_in_valid,
   input  logic             fma_in_ready,
   output logic [OPW-1:0]   fma_a,
   output logic [OPW-1:0]   fma_b,
   output logic [ACCW-1:0]  fma_c,
   input  logic             fma_out_valid,
   input  logic [ACCW-1:0]  fma_out,
   output logic [NREQ-1:0]  rsp_valid,
   output logic [IDW-1:0]   rsp_id,
   output logic [ACCW-1:0]  rsp_data,
   output logic [CW-1:0]    inflight,
   output logic             err_orphan
);

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] cand;
   logic [IDW-1:0] head;
   logic           found;
   logic           full;
   logic           empty;
   logic           issue;
   logic           pop;

   // No full-bypass: a same-cycle pop does not free a slot for issue.
   assign fma_in_valid = (|req_valid) & ~full;
   assign issue        = fma_in_valid & fma_in_ready;
   assign pop          = fma_out_valid & ~empty;
   assign req_ready    = issue ? (NREQ'(1) << winner) : '0;

   // Search starts one past the last winner, wrapping at NREQ.
   always_comb begin
      winner = rr_ptr;
      cand   = rr_ptr;
      found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      fma_a = '0;
      fma_b = '0;
      fma_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == IDW'(i)) begin
            fma_a = req_a[i*OPW +: OPW];
            fma_b = req_b[i*OPW +: OPW];
            fma_c = req_c[i*ACCW +: ACCW];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rr_ptr <= IDW'(NREQ - 1);
      else if (issue) rr_ptr <= winner;
   end

   tag_fifo #(
      .W     (IDW),
      .DEPTH (DEPTH)
   ) u_tags (
      .clk   (clk),
      .rstn  (rstn),
      .push  (issue),
      .pop   (pop),
      .din   (winner),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (inflight)
   );

   // A result with no tag outstanding is dropped and latched as an error.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid  <= '0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         err_orphan <= 1'b0;
      end else begin
         rsp_valid <= pop ? (NREQ'(1) << head) : '0;
         if (pop) begin
            rsp_id   <= head;
            rsp_data <= fma_out;
         end
         if (fma_out_valid && empty) err_orphan <= 1'b1;
      end
   end

endmodule
